dmr_commit_ctrl: RTL and testbench
==================================

DMR_COMMIT_CTRL -- requirements
Module: dmr_commit_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write-data width.
REQ-003 SHALL have parameter MAX_SKEW, default 4, maximum number of cycles between the two cores' requests.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, error-counter width.
REQ-005 SHALL have ports (one clock; reset is asynchronous and active-high):
 clk_i  in  1  clock.
 rst_i  in  1  asynchronous, active-high reset.
 a_req_i / b_req_i  in  1  core A/B request, held until the matching gnt.
 a_we_i / b_we_i  in  1  write enable.
 a_addr_i / b_addr_i  in  ADDR_WIDTH  address.
 a_wdata_i / b_wdata_i  in  DATA_WIDTH  write data.
 a_gnt_o / b_gnt_o  out  1  one-cycle grant to each core.
 mem_req_o  out  1  memory request.
 mem_we_o  out  1  memory write enable.
 mem_addr_o  out  ADDR_WIDTH  memory address.
 mem_wdata_o  out  DATA_WIDTH  memory write data.
 mem_gnt_i  in  1  memory accepts the request.
 recover_i  in  1  pulse from the recovery unit that clears a fault.
 mismatch_o  out  1  one-cycle pulse on each detected error.
 fault_o  out  1  sticky fault level.
 err_cnt_o  out  CNT_WIDTH  saturating error count.

Function
REQ-006 SHALL implement the states IDLE, SKEW, ISSUE, GRANT and FAULT.
REQ-007 SHALL define match as: we equal, addr equal, and wdata equal when we=1 (wdata ignored when we=0).
REQ-008 IDLE: if both req are high, SHALL go to ISSUE on match and to FAULT on mismatch.
REQ-009 IDLE: if exactly one req is high, SHALL go to SKEW and load the skew counter with 1.
REQ-010 SKEW: when both req are high, SHALL apply the REQ-008 rule; otherwise it SHALL increment the counter and go to FAULT when the counter reaches MAX_SKEW.
REQ-011 On entry to ISSUE, SHALL register A's we/addr/wdata into mem_*_o; mem_req_o SHALL be high throughout ISSUE.
REQ-012 Latency: requests that match at cycle 0 SHALL give mem_req_o=1 at cycle 1.
REQ-013 ISSUE: mem_*_o SHALL stay stable until mem_gnt_i=1; the controller SHALL then go to GRANT.
REQ-014 GRANT SHALL last exactly one cycle, assert a_gnt_o and b_gnt_o in the same cycle, deassert mem_req_o and return to IDLE.
REQ-015 Entry to FAULT SHALL pulse mismatch_o for exactly one cycle, set fault_o, and issue no memory request or grant.
REQ-016 FAULT SHALL be left only on recover_i=1, returning to IDLE with fault_o cleared on the next cycle.
REQ-017 recover_i outside FAULT SHALL be ignored.
REQ-018 mem_gnt_i while mem_req_o=0 SHALL be ignored.
REQ-019 Request changes from either core during ISSUE or GRANT SHALL be ignored.
REQ-020 With MAX_SKEW=1, a single-sided request SHALL fault on the next cycle.

Reset
REQ-021 rst_i=1 SHALL immediately and asynchronously force IDLE and clear the skew counter and err_cnt_o.
REQ-022 rst_i=1 SHALL immediately and asynchronously drive all outputs to 0, including in the middle of a memory transaction.
REQ-023 After rst_i falls, SHALL evaluate requests from the first rising clock edge.

Configuration
REQ-024 SHALL use the macro DMR_ERR_CNT_EN to compile the error counter in or out.
REQ-025 With DMR_ERR_CNT_EN defined: err_cnt_o SHALL increment by 1 on each mismatch_o pulse and saturate at all-ones.
REQ-026 Without DMR_ERR_CNT_EN: err_cnt_o SHALL be constant 0 and no counter flops SHALL exist; all other behaviour SHALL be unchanged.

Verification
REQ-027 Both cores write addr 0x100, data 0xCAFE at cycle 0 and mem_gnt_i is high at cycle 3 -> mem_req_o is high in cycles 1-3, mem_wdata_o=0xCAFE, and both gnt are high at cycle 4.
REQ-028 A has wdata 0x1, B has wdata 0x2, same addr, we=1 -> mismatch_o is pulsed once, fault_o=1, err_cnt_o=1, mem_req_o stays 0; recover_i -> IDLE.
REQ-029 Both cores read (we=0) addr 0x40 with differing wdata -> treated as a match and the memory read is issued.
REQ-030 A requests at cycle 0 and B at cycle 2 with MAX_SKEW=4 -> commit; B never requests -> fault at cycle 4.
REQ-031 rst_i is asserted during ISSUE -> mem_req_o=0 immediately, and IDLE is entered on release.
REQ-032 With CNT_WIDTH=2, force 5 faults -> err_cnt_o=3 when DMR_ERR_CNT_EN is defined, and err_cnt_o=0 when it is not.

Source files
------------

// File: rtl/dmr_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmr_commit_ctrl
// Brief   : Dual-modular-redundant commit controller. It compares the memory
//           requests of two lock-stepped cores, issues one memory access when
//           they agree, and raises a sticky fault when they disagree or drift
//           apart. Optional error counter: define DMR_ERR_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module dmr_commit_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_SKEW   = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    output logic                  a_gnt_o,
    output logic                  b_gnt_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  recover_i,
    output logic                  mismatch_o,
    output logic                  fault_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
);

    localparam int SKEW_W = (MAX_SKEW < 2) ? 1 : $clog2(MAX_SKEW + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SKEW  = 3'd1,
        S_ISSUE = 3'd2,
        S_GRANT = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            r_state;
    logic [SKEW_W-1:0] r_skew_cnt;

    logic w_match;
    logic w_both;
    logic w_one;
    logic w_cmp_state;
    logic w_skew_expired;
    logic w_to_issue;
    logic w_to_fault;

    // Write data only takes part in the comparison for writes.
    assign w_match = (a_we_i == b_we_i) && (a_addr_i == b_addr_i) &&
                     (!a_we_i || (a_wdata_i == b_wdata_i));
    assign w_both         = a_req_i & b_req_i;
    assign w_one          = a_req_i ^ b_req_i;
    assign w_cmp_state    = (r_state == S_IDLE) || (r_state == S_SKEW);
    assign w_skew_expired = (r_skew_cnt >= SKEW_W'(MAX_SKEW - 1));
    assign w_to_issue     = w_cmp_state && w_both && w_match;
    // A lone request faults on cycle MAX_SKEW; with MAX_SKEW=1 straight from IDLE.
    assign w_to_fault = (w_cmp_state && w_both && !w_match) ||
                        ((r_state == S_IDLE) && w_one && (MAX_SKEW <= 1)) ||
                        ((r_state == S_SKEW) && !w_both && w_skew_expired);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_skew_cnt  <= '0;
            a_gnt_o     <= 1'b0;
            b_gnt_o     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mismatch_o  <= 1'b0;
            fault_o     <= 1'b0;
        end else begin
            mismatch_o <= w_to_fault;
            case (r_state)
                S_IDLE, S_SKEW: begin
                    if (w_to_issue) begin
                        r_state     <= S_ISSUE;
                        r_skew_cnt  <= '0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= a_we_i;
                        mem_addr_o  <= a_addr_i;
                        mem_wdata_o <= a_wdata_i;
                    end else if (w_to_fault) begin
                        r_state    <= S_FAULT;
                        r_skew_cnt <= '0;
                        fault_o    <= 1'b1;
                    end else if (r_state == S_SKEW) begin
                        r_skew_cnt <= r_skew_cnt + SKEW_W'(1);
                    end else if (w_one) begin
                        r_state    <= S_SKEW;
                        r_skew_cnt <= SKEW_W'(1);
                    end
                end
                S_ISSUE: begin
                    if (mem_gnt_i) begin
                        r_state   <= S_GRANT;
                        mem_req_o <= 1'b0;
                        a_gnt_o   <= 1'b1;
                        b_gnt_o   <= 1'b1;
                    end
                end
                S_GRANT: begin
                    r_state <= S_IDLE;
                    a_gnt_o <= 1'b0;
                    b_gnt_o <= 1'b0;
                end
                S_FAULT: begin
                    if (recover_i) begin
                        r_state <= S_IDLE;
                        fault_o <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMR_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] r_err_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (w_to_fault && (r_err_cnt != {CNT_WIDTH{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmr_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmr_commit_ctrl
// Brief   : Self-checking bench for dmr_commit_ctrl (MAX_SKEW=4, CNT_WIDTH=2,
//           plus a MAX_SKEW=1 instance); expected accesses go through a queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmr_commit_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
    logic [31:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;
    logic        mem_gnt = 1'b0, recover = 1'b0;
    logic        a_gnt, b_gnt, mem_req, mem_we, mismatch, fault;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  err_cnt;

    logic        a_req1 = 1'b0;
    logic        a_gnt1, b_gnt1, mem_req1, mem_we1, mismatch1, fault1;
    logic [31:0] mem_addr1, mem_wdata1;
    logic [1:0]  err_cnt1;

    txn_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   n_faults = 0;

    always #5 clk = ~clk;

    dmr_commit_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_SKEW(4), .CNT_WIDTH(2)
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .a_gnt_o(a_gnt), .b_gnt_o(b_gnt),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .recover_i(recover),
        .mismatch_o(mismatch), .fault_o(fault), .err_cnt_o(err_cnt)
    );

    dmr_commit_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_SKEW(1), .CNT_WIDTH(2)
    ) u_dut_skew1 (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req1), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .b_req_i(1'b0), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .a_gnt_o(a_gnt1), .b_gnt_o(b_gnt1),
        .mem_req_o(mem_req1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
        .mem_wdata_o(mem_wdata1), .mem_gnt_i(mem_gnt), .recover_i(recover),
        .mismatch_o(mismatch1), .fault_o(fault1), .err_cnt_o(err_cnt1)
    );

    function automatic logic [1:0] exp_err();
`ifdef DMR_ERR_CNT_EN
        return (n_faults > 3) ? 2'd3 : 2'(n_faults);
`else
        return 2'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_pair(input logic we, input logic [31:0] addr,
                              input logic [31:0] wa, input logic [31:0] wb);
        a_we = we; b_we = we; a_addr = addr; b_addr = addr;
        a_wdata = wa; b_wdata = wb; a_req = 1'b1; b_req = 1'b1;
        exp_q.push_back(txn_t'({we, addr, wa}));
    endtask

    task automatic drop_reqs();
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({a_gnt, b_gnt, mem_req, mem_we, mismatch, fault, err_cnt, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b req=%b mism=%b fault=%b cnt=%0d required all 0",
                     a_gnt, b_gnt, mem_req, mismatch, fault, err_cnt);
        end
        tick(); tick();
        rst = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++;
        if ({a_gnt, b_gnt, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL idle_gnt_ignored: gnt=%b%b req=%b required 000", a_gnt, b_gnt, mem_req);
        end
    endtask

    task automatic test_commit();
        txn_t t;
        issue_pair(1'b1, 32'h100, 32'hCAFE, 32'hCAFE);
        tick();
        checks++;
        if (mem_req !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL commit_latency: mem_req_o=%b required 1", mem_req);
        end else begin
            t = exp_q.pop_front();
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== t) begin
                errors++;
                $display("FAIL commit_data: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                         mem_we, mem_addr, mem_wdata, t.we, t.addr, t.wdata);
            end
        end
        tick();
        a_wdata = 32'hBEEF; a_addr = 32'h999;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL commit_hold_c2: mem_req_o=%b required 1", mem_req);
        end
        tick();
        checks++;
        if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'hCAFE}) begin
            errors++;
            $display("FAIL commit_stable_c3: req=%b addr=%h wdata=%h required 1 100 cafe",
                     mem_req, mem_addr, mem_wdata);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++;
        if ({a_gnt, b_gnt, mem_req} !== 3'b110) begin
            errors++;
            $display("FAIL commit_grant: gnt=%b%b req=%b required 110", a_gnt, b_gnt, mem_req);
        end
        drop_reqs();
        tick();
        checks++;
        if ({a_gnt, b_gnt, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL commit_grant_one_cycle: gnt=%b%b req=%b required 000", a_gnt, b_gnt, mem_req);
        end
    endtask

    task automatic test_read_match();
        txn_t t;
        issue_pair(1'b0, 32'h40, 32'h1, 32'h2);
        tick();
        checks++;
        if (mem_req !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL read_issue: mem_req_o=%b mismatch_o=%b required 1 0", mem_req, mismatch);
        end else begin
            t = exp_q.pop_front();
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== t) begin
                errors++;
                $display("FAIL read_data: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                         mem_we, mem_addr, mem_wdata, t.we, t.addr, t.wdata);
            end
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++;
        if ({a_gnt, b_gnt, mismatch, fault} !== 4'b1100) begin
            errors++;
            $display("FAIL read_grant: gnt=%b%b mism=%b fault=%b required 1100", a_gnt, b_gnt, mismatch, fault);
        end
        drop_reqs();
        tick();
    endtask

    task automatic test_mismatch();
        a_we = 1'b1; b_we = 1'b1; a_addr = 32'h200; b_addr = 32'h200;
        a_wdata = 32'h1; b_wdata = 32'h2; a_req = 1'b1; b_req = 1'b1;
        n_faults++;
        tick();
        checks++;
        if ({mismatch, fault, mem_req, err_cnt} !== {3'b110, exp_err()}) begin
            errors++;
            $display("FAIL mismatch_entry: mism=%b fault=%b req=%b cnt=%0d required 1 1 0 %0d",
                     mismatch, fault, mem_req, err_cnt, exp_err());
        end
        drop_reqs();
        tick();
        checks++;
        if ({mismatch, fault, mem_req, a_gnt, b_gnt} !== 5'b01000) begin
            errors++;
            $display("FAIL mismatch_pulse: mism=%b fault=%b req=%b gnt=%b%b required 01000",
                     mismatch, fault, mem_req, a_gnt, b_gnt);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        recover = 1'b1;
        checks++;
        if ({fault, mem_req, a_gnt, b_gnt} !== 4'b1000) begin
            errors++;
            $display("FAIL fault_sticky: fault=%b req=%b gnt=%b%b required 1000", fault, mem_req, a_gnt, b_gnt);
        end
        tick();
        recover = 1'b0;
        checks++;
        if ({fault, mismatch, err_cnt} !== {2'b00, exp_err()}) begin
            errors++;
            $display("FAIL recover: fault=%b mism=%b cnt=%0d required 0 0 %0d", fault, mismatch, err_cnt, exp_err());
        end
        tick();
    endtask

    task automatic test_skew();
        txn_t t;
        a_we = 1'b1; b_we = 1'b1; a_addr = 32'h300; b_addr = 32'h300;
        a_wdata = 32'h55; b_wdata = 32'h55; a_req = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if ({mem_req, fault} !== 2'b00) begin
                errors++;
                $display("FAIL skew_wait_c%0d: req=%b fault=%b required 00", i, mem_req, fault);
            end
        end
        b_req = 1'b1;
        exp_q.push_back(txn_t'({1'b1, 32'h300, 32'h55}));
        tick();
        checks++;
        if (mem_req !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL skew_commit: mem_req_o=%b fault=%b required 1 0", mem_req, fault);
        end else begin
            t = exp_q.pop_front();
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== t) begin
                errors++;
                $display("FAIL skew_data: got addr=%h wdata=%h required addr=%h wdata=%h",
                         mem_addr, mem_wdata, t.addr, t.wdata);
            end
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        drop_reqs();
        tick();
        a_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (fault !== 1'b0) begin
                errors++;
                $display("FAIL skew_early_c%0d: fault=%b required 0", i, fault);
            end
        end
        n_faults++;
        tick();
        checks++;
        if ({mismatch, fault, mem_req, err_cnt} !== {3'b110, exp_err()}) begin
            errors++;
            $display("FAIL skew_timeout: mism=%b fault=%b req=%b cnt=%0d required 1 1 0 %0d",
                     mismatch, fault, mem_req, err_cnt, exp_err());
        end
        drop_reqs();
        recover = 1'b1;
        tick();
        recover = 1'b0;
        tick();
    endtask

    task automatic test_skew_one();
        a_req1 = 1'b1;
        tick();
        a_req1 = 1'b0;
        checks++;
        if ({mismatch1, fault1, mem_req1, fault} !== 4'b1100) begin
            errors++;
            $display("FAIL skew1_fault: mism=%b fault=%b req=%b main_fault=%b required 1100",
                     mismatch1, fault1, mem_req1, fault);
        end
        tick();
        recover = 1'b1;
        tick();
        recover = 1'b0;
        checks++;
        if (fault1 !== 1'b0) begin
            errors++;
            $display("FAIL skew1_recover: fault=%b required 0", fault1);
        end
    endtask

    task automatic test_reset_mid();
        txn_t t;
        issue_pair(1'b1, 32'h400, 32'h77, 32'h77);
        tick();
        t = exp_q.pop_front();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, t}) begin
            errors++;
            $display("FAIL rstmid_issue: req=%b addr=%h required 1 %h", mem_req, mem_addr, t.addr);
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_faults = 0;
        checks++;
        if ({a_gnt, b_gnt, mem_req, mem_we, mismatch, fault, err_cnt, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: req=%b addr=%h cnt=%0d required all 0", mem_req, mem_addr, err_cnt);
        end
        drop_reqs();
        tick(); tick();
        rst = 1'b0;
        issue_pair(1'b1, 32'h404, 32'h88, 32'h88);
        tick();
        checks++;
        if (mem_req !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL rstmid_after: mem_req_o=%b required 1", mem_req);
        end else begin
            t = exp_q.pop_front();
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== t) begin
                errors++;
                $display("FAIL rstmid_data: got addr=%h wdata=%h required addr=%h wdata=%h",
                         mem_addr, mem_wdata, t.addr, t.wdata);
            end
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        drop_reqs();
        tick();
    endtask

    task automatic test_err_sat();
        for (int k = 0; k < 5; k++) begin
            a_we = 1'b1; b_we = 1'b1; a_addr = 32'h500; b_addr = 32'h500;
            a_wdata = 32'(k); b_wdata = 32'(k + 16); a_req = 1'b1; b_req = 1'b1;
            n_faults++;
            tick();
            checks++;
            if ({fault, err_cnt} !== {1'b1, exp_err()}) begin
                errors++;
                $display("FAIL errcnt_step%0d: fault=%b cnt=%0d required 1 %0d", k, fault, err_cnt, exp_err());
            end
            drop_reqs();
            recover = 1'b1;
            tick();
            recover = 1'b0;
            tick();
        end
        checks++;
`ifdef DMR_ERR_CNT_EN
        if (err_cnt !== 2'd3) begin
            errors++;
            $display("FAIL errcnt_saturate: cnt=%0d required 3", err_cnt);
        end
`else
        if (err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL errcnt_disabled: cnt=%0d required 0", err_cnt);
        end
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected accesses never seen, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_read_match();
        test_mismatch();
        test_skew();
        test_skew_one();
        test_reset_mid();
        test_err_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
